// File: rtl/div_ctrl_if.sv
// Divider-side handshake bundle: the controller drives start/annul/operands, the divider returns ready/result.
interface div_ctrl_if #(
  parameter int DW = 32
);
  logic            start_o;
  logic            annul_o;
  logic            signed_o;
  logic [DW-1:0]   opdata1_o;
  logic [DW-1:0]   opdata2_o;
  logic            ready_i;
  logic [2*DW-1:0] result_i;

  modport master (
    output start_o, annul_o, signed_o, opdata1_o, opdata2_o,
    input  ready_i, result_i
  );

  modport slave (
    input  start_o, annul_o, signed_o, opdata1_o, opdata2_o,
    output ready_i, result_i
  );
endinterface

// File: rtl/div_ctrl.sv
// EX-stage divider initiator: issue + divider latency + 1 capture cycle, HI/LO strobe the cycle after ready;
// stalls EX while busy, holds results under ex_stall_i. DIV_FASTPATH_EN: divisor 0/1 resolved without the divider.
module div_ctrl #(
  parameter int DW        = 32,
  parameter int CLEAR_CYC = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          div_req_i,
  input  logic          signed_i,
  input  logic [DW-1:0] op1_i,
  input  logic [DW-1:0] op2_i,
  input  logic          flush_i,
  input  logic          ex_stall_i,
  div_ctrl_if.master    div_if,
  output logic          stall_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o,
  output logic          hilo_we_o
);

  localparam int CW = (CLEAR_CYC > 1) ? $clog2(CLEAR_CYC) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DONE, CLEAR} state_e;

  state_e        state_q, state_d;
  logic          start_q, start_d;
  logic          signed_q, signed_d;
  logic [DW-1:0] op1_q, op1_d;
  logic [DW-1:0] op2_q, op2_d;
  logic [DW-1:0] hi_q, hi_d;
  logic [DW-1:0] lo_q, lo_d;
  logic          we_q, we_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          stall_c;
  logic          annul_c;

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    signed_d = signed_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    we_d     = 1'b0;
    cnt_d    = cnt_q;
    stall_c  = 1'b0;
    annul_c  = 1'b0;
    case (state_q)
      IDLE: begin
        stall_c = div_req_i & ~flush_i;
        if (div_req_i && !flush_i) begin
          signed_d = signed_i;
          op1_d    = op1_i;
          op2_d    = op2_i;
`ifdef DIV_FASTPATH_EN
          if (op2_i == '0 || op2_i == DW'(1)) begin
            hi_d    = '0;
            lo_d    = (op2_i == '0) ? '0 : op1_i;
            we_d    = 1'b1;
            state_d = DONE;
          end else begin
            start_d = 1'b1;
            state_d = WAIT;
          end
`else
          start_d = 1'b1;
          state_d = WAIT;
`endif
        end
      end
      WAIT: begin
        stall_c = 1'b1;
        // A flush must win over a same-cycle ready so a killed divide never writes HI/LO.
        if (flush_i) begin
          annul_c = 1'b1;
          start_d = 1'b0;
          cnt_d   = CW'(CLEAR_CYC - 1);
          state_d = CLEAR;
        end else if (div_if.ready_i) begin
          hi_d    = div_if.result_i[2*DW-1:DW];
          lo_d    = div_if.result_i[DW-1:0];
          start_d = 1'b0;
          we_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (flush_i || !ex_stall_i) begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      start_q  <= 1'b0;
      signed_q <= 1'b0;
      op1_q    <= '0;
      op2_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      we_q     <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      signed_q <= signed_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
    end
  end

  assign div_if.start_o   = start_q;
  assign div_if.annul_o   = annul_c;
  assign div_if.signed_o  = signed_q;
  assign div_if.opdata1_o = op1_q;
  assign div_if.opdata2_o = op2_q;
  assign stall_o          = stall_c;
  assign hi_o             = hi_q;
  assign lo_o             = lo_q;
  assign hilo_we_o        = we_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl; the divider is played by the bench, which returns hand-computed results.
module tb_div_ctrl;

  logic        clk;
  logic        rst;
  logic        div_req_i;
  logic        signed_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic        flush_i;
  logic        ex_stall_i;
  logic        stall_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        hilo_we_o;

  int n_chk;
  int n_err;

  div_ctrl_if #(.DW(32)) dif ();

  div_ctrl #(.DW(32), .CLEAR_CYC(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_req_i  (div_req_i),
    .signed_i   (signed_i),
    .op1_i      (op1_i),
    .op2_i      (op2_i),
    .flush_i    (flush_i),
    .ex_stall_i (ex_stall_i),
    .div_if     (dif),
    .stall_o    (stall_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .hilo_we_o  (hilo_we_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in IDLE, then step into WAIT and check the latched operands.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    div_req_i = 1'b1;
    signed_i  = sgn;
    op1_i     = a;
    op2_i     = b;
    #1;
    chk("issue_stall", stall_o, 1);
    tick();
    chk("issue_start", dif.start_o, 1);
    chk("issue_ops", {dif.opdata1_o, dif.opdata2_o}, {a, b});
    chk("issue_sgn", dif.signed_o, sgn);
    // Perturb EX inputs: the latched copies must not follow them.
    op1_i    = ~a;
    op2_i    = ~b;
    signed_i = ~sgn;
  endtask

  task automatic hold(input int n, input logic [31:0] a);
    for (int i = 0; i < n; i++) begin
      chk("wait_hold", {dif.start_o, stall_o, dif.annul_o, hilo_we_o, dif.opdata1_o},
          {1'b1, 1'b1, 1'b0, 1'b0, a});
      tick();
    end
  endtask

  task automatic complete(input logic [31:0] hi, input logic [31:0] lo);
    dif.ready_i  = 1'b1;
    dif.result_i = {hi, lo};
    tick();
    dif.ready_i  = 1'b0;
    dif.result_i = 64'hDEAD_BEEF_0BAD_F00D;
    chk("done_we", hilo_we_o, 1);
    chk("done_hilo", {hi_o, lo_o}, {hi, lo});
    chk("done_start_stall", {dif.start_o, stall_o}, 0);
  endtask

  task automatic retire();
    div_req_i = 1'b0;
    tick();
    chk("retire_we", hilo_we_o, 0);
  endtask

  initial begin
    n_chk        = 0;
    n_err        = 0;
    rst          = 1'b0;
    div_req_i    = 1'b0;
    signed_i     = 1'b0;
    op1_i        = '0;
    op2_i        = '0;
    flush_i      = 1'b0;
    ex_stall_i   = 1'b0;
    dif.ready_i  = 1'b0;
    dif.result_i = '0;
    #12;
    chk("rst_ctl", {dif.start_o, dif.annul_o, dif.signed_o, hilo_we_o, stall_o}, 0);
    chk("rst_ops", {dif.opdata1_o, dif.opdata2_o}, 0);
    chk("rst_hilo", {hi_o, lo_o}, 0);
    rst = 1'b1;
    tick();

    // DIVU 100/7 -> q=14 r=2
    issue(1'b0, 32'd100, 32'd7);
    hold(5, 32'd100);
    complete(32'd2, 32'd14);
    retire();

    // DIV -7/2 -> q=-3 r=-1
    issue(1'b1, 32'hFFFF_FFF9, 32'd2);
    hold(6, 32'hFFFF_FFF9);
    complete(32'hFFFF_FFFF, 32'hFFFF_FFFD);
    retire();

    // Flush 10 cycles into WAIT with a coincident ready: result dropped, 2 CLEAR cycles.
    issue(1'b0, 32'd100, 32'd7);
    hold(10, 32'd100);
    flush_i      = 1'b1;
    dif.ready_i  = 1'b1;
    dif.result_i = 64'h1111_1111_2222_2222;
    #1;
    chk("flush_annul", dif.annul_o, 1);
    tick();
    flush_i     = 1'b0;
    dif.ready_i = 1'b0;
    op1_i       = 32'd50;
    op2_i       = 32'd5;
    signed_i    = 1'b0;
    #1;
    chk("clear1", {dif.start_o, stall_o, dif.annul_o, hilo_we_o}, 0);
    tick();
    chk("clear2", {dif.start_o, stall_o, hilo_we_o}, 0);
    tick();
    chk("post_clear_stall", {dif.start_o, stall_o}, 2'b01);
    tick();
    chk("reissue", {dif.start_o, dif.opdata1_o, dif.opdata2_o}, {1'b1, 32'd50, 32'd5});
    hold(2, 32'd50);
    complete(32'd0, 32'd10);
    retire();

    // Result under ex_stall for 3 cycles with req held: one strobe, no re-issue.
    issue(1'b0, 32'd9, 32'd4);
    hold(3, 32'd9);
    ex_stall_i = 1'b1;
    complete(32'd1, 32'd2);
    tick();
    chk("exst_hold2", {hilo_we_o, dif.start_o, stall_o, hi_o, lo_o}, {3'b000, 32'd1, 32'd2});
    tick();
    chk("exst_hold3", {hilo_we_o, dif.start_o, stall_o}, 0);
    ex_stall_i = 1'b0;
    div_req_i  = 1'b0;
    tick();
    chk("exst_idle", {hilo_we_o, dif.start_o, stall_o}, 0);
    tick();
    chk("exst_noreissue", dif.start_o, 0);

    // DIVU 5/0 -> {0,0}
`ifdef DIV_FASTPATH_EN
    div_req_i = 1'b1;
    signed_i  = 1'b0;
    op1_i     = 32'd5;
    op2_i     = 32'd0;
    #1;
    chk("fp_stall", stall_o, 1);
    tick();
    chk("fp_div0", {dif.start_o, hilo_we_o, stall_o, hi_o, lo_o}, {3'b010, 32'd0, 32'd0});
    retire();
    div_req_i = 1'b1;
    op1_i     = 32'd9;
    op2_i     = 32'd1;
    tick();
    chk("fp_div1", {dif.start_o, hilo_we_o, hi_o, lo_o}, {2'b01, 32'd0, 32'd9});
    retire();
`else
    issue(1'b0, 32'd5, 32'd0);
    hold(4, 32'd5);
    complete(32'd0, 32'd0);
    retire();
`endif

    // Async reset mid-WAIT, then a normal divide.
    issue(1'b0, 32'd77, 32'd3);
    hold(3, 32'd77);
    rst       = 1'b0;
    div_req_i = 1'b0;
    #1;
    chk("arst_ctl", {dif.start_o, dif.annul_o, dif.signed_o, hilo_we_o, stall_o}, 0);
    chk("arst_ops", {dif.opdata1_o, dif.opdata2_o, hi_o, lo_o}, 0);
    tick();
    rst = 1'b1;
    tick();
    issue(1'b0, 32'd77, 32'd3);
    hold(2, 32'd77);
    complete(32'd2, 32'd25);
    retire();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
